// File: rtl/dii_package.sv
// Shared DII ring definitions: flit layout, packet type/subtype codes and flags field positions.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam int unsigned FLAGS_TYPE_MSB = 15;
  localparam int unsigned FLAGS_TYPE_LSB = 14;
  localparam int unsigned FLAGS_SUB_MSB  = 13;
  localparam int unsigned FLAGS_SUB_LSB  = 10;

  localparam logic [1:0] TYPE_REG = 2'b00;

  localparam logic [3:0] SUB_REQ_READ       = 4'h0;
  localparam logic [3:0] SUB_REQ_WRITE      = 4'h2;
  localparam logic [3:0] SUB_RESP_READ      = 4'h8;
  localparam logic [3:0] SUB_RESP_READ_ERR  = 4'h9;
  localparam logic [3:0] SUB_RESP_WRITE     = 4'hA;
  localparam logic [3:0] SUB_RESP_WRITE_ERR = 4'hB;

  function automatic logic [15:0] make_flags(input logic [1:0] ptype, input logic [3:0] sub);
    logic [15:0] f;
    f = '0;
    f[FLAGS_TYPE_MSB:FLAGS_TYPE_LSB] = ptype;
    f[FLAGS_SUB_MSB:FLAGS_SUB_LSB]   = sub;
    return f;
  endfunction

endpackage

// File: rtl/dii_reg_responder.sv
// DII register endpoint: parses REG read/write requests from the ring, performs one register
// access with timeout, and returns a success or error response packet.
module dii_reg_responder
  import dii_package::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id,
  input  dii_flit     debug_in,
  output logic        debug_in_ready,
  output dii_flit     debug_out,
  input  logic        debug_out_ready,
  output logic        reg_request,
  output logic        reg_write,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  input  logic        reg_err,
  input  logic [15:0] reg_rdata
);

  typedef enum logic [3:0] {
    StRxDest,
    StRxSrc,
    StRxFlags,
    StRxAddr,
    StRxWdata,
    StRxDrain,
    StAccess,
    StTxDest,
    StTxSrc,
    StTxFlags,
    StTxData
  } state_e;

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  // Set when a REG request overran its final word: drain it, then answer with an error.
  logic        drain_err_q, drain_err_d;
  logic [7:0]  cnt_q, cnt_d;
  dii_flit     out_q, out_d;

  logic        in_fire, out_fire;
  logic [1:0]  in_type;
  logic [3:0]  in_sub;
  logic [3:0]  resp_sub;
  logic [15:0] resp_flags;

  assign in_fire  = debug_in.valid & debug_in_ready;
  assign out_fire = out_q.valid & debug_out_ready;
  assign in_type  = debug_in.data[FLAGS_TYPE_MSB:FLAGS_TYPE_LSB];
  assign in_sub   = debug_in.data[FLAGS_SUB_MSB:FLAGS_SUB_LSB];

  assign resp_sub   = write_q ? (err_q ? SUB_RESP_WRITE_ERR : SUB_RESP_WRITE)
                              : (err_q ? SUB_RESP_READ_ERR  : SUB_RESP_READ);
  assign resp_flags = make_flags(TYPE_REG, resp_sub);

  assign debug_in_ready = state_q inside {StRxDest, StRxSrc, StRxFlags, StRxAddr, StRxWdata,
                                         StRxDrain};
  assign reg_request    = (state_q == StAccess);
  assign reg_write      = write_q;
  assign reg_addr       = addr_q;
  assign reg_wdata      = wdata_q;
  assign debug_out      = out_q;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    drain_err_d = drain_err_q;
    cnt_d       = cnt_q;
    out_d       = out_q;

    unique case (state_q)
      StRxDest: begin
        if (in_fire) state_d = debug_in.last ? StRxDest : StRxSrc;
      end
      StRxSrc: begin
        if (in_fire) begin
          src_d   = debug_in.data;
          state_d = debug_in.last ? StRxDest : StRxFlags;
        end
      end
      StRxFlags: begin
        if (in_fire) begin
          write_d     = (in_sub == SUB_REQ_WRITE);
          drain_err_d = 1'b0;
          if (debug_in.last) begin
            state_d = StRxDest;
          end else if (in_type != TYPE_REG ||
                       (in_sub != SUB_REQ_READ && in_sub != SUB_REQ_WRITE)) begin
            state_d = StRxDrain;
          end else begin
            state_d = StRxAddr;
          end
        end
      end
      StRxAddr: begin
        if (in_fire) begin
          addr_d = debug_in.data;
          if (write_q) begin
            state_d = debug_in.last ? StRxDest : StRxWdata;
          end else if (debug_in.last) begin
            state_d = StAccess;
          end else begin
            drain_err_d = 1'b1;
            state_d     = StRxDrain;
          end
        end
      end
      StRxWdata: begin
        if (in_fire) begin
          wdata_d = debug_in.data;
          if (debug_in.last) begin
            state_d = StAccess;
          end else begin
            drain_err_d = 1'b1;
            state_d     = StRxDrain;
          end
        end
      end
      StRxDrain: begin
        if (in_fire && debug_in.last) begin
          if (drain_err_q) begin
            err_d   = 1'b1;
            out_d   = '{valid: 1'b1, last: 1'b0, data: src_q};
            state_d = StTxDest;
          end else begin
            state_d = StRxDest;
          end
        end
      end
      StAccess: begin
        cnt_d = cnt_q + 8'd1;
        if (reg_err || reg_ack || cnt_q == LastCount) begin
          err_d   = reg_err | ~reg_ack;
          rdata_d = reg_rdata;
          cnt_d   = '0;
          out_d   = '{valid: 1'b1, last: 1'b0, data: src_q};
          state_d = StTxDest;
        end
      end
      StTxDest: begin
        if (out_fire) begin
          out_d   = '{valid: 1'b1, last: 1'b0, data: id};
          state_d = StTxSrc;
        end
      end
      StTxSrc: begin
        if (out_fire) begin
          out_d   = '{valid: 1'b1, last: err_q | write_q, data: resp_flags};
          state_d = StTxFlags;
        end
      end
      StTxFlags: begin
        if (out_fire) begin
          if (!err_q && !write_q) begin
            out_d   = '{valid: 1'b1, last: 1'b1, data: rdata_q};
            state_d = StTxData;
          end else begin
            out_d   = '0;
            state_d = StRxDest;
          end
        end
      end
      StTxData: begin
        if (out_fire) begin
          out_d   = '0;
          state_d = StRxDest;
        end
      end
      default: state_d = StRxDest;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRxDest;
      src_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      drain_err_q <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      drain_err_q <= drain_err_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_dii_reg_responder.sv
// Directed bench for dii_reg_responder: read, write, error, timeout, malformed, drain,
// backpressure and mid-access reset sequences with hand-computed responses.
module tb_dii_reg_responder;
  import dii_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id;
  dii_flit     debug_in;
  dii_flit     debug_out;
  logic        debug_in_ready;
  logic        debug_out_ready;
  logic        reg_request;
  logic        reg_write;
  logic [15:0] reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_ack;
  logic        reg_err;
  logic [15:0] reg_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] rx_data [16];
  logic        rx_last [16];
  int          rx_count;
  int          rx_first;
  int          hold_err;
  int          in_ready_err;
  int          req_seen;

  dii_reg_responder #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id             (id),
    .debug_in       (debug_in),
    .debug_in_ready (debug_in_ready),
    .debug_out      (debug_out),
    .debug_out_ready(debug_out_ready),
    .reg_request    (reg_request),
    .reg_write      (reg_write),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_ack        (reg_ack),
    .reg_err        (reg_err),
    .reg_rdata      (reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int waited;
    waited = 0;
    @(negedge clk);
    debug_in = '{valid: 1'b1, last: l, data: d};
    while (!debug_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!debug_in_ready) check("in_ready_wait", {31'd0, debug_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    debug_in = '0;
  endtask

  task automatic send_read(input logic [15:0] addr);
    send_word(16'h0005, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(addr, 1'b1);
  endtask

  task automatic send_write(input logic [15:0] addr, input logic [15:0] data);
    send_word(16'h0005, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0800, 1'b0);
    send_word(addr, 1'b0);
    send_word(data, 1'b1);
  endtask

  // Read whose access is acknowledged in its second ACCESS cycle.
  task automatic read_with_ack(input string tag, input logic [15:0] addr,
                               input logic [15:0] data);
    send_read(addr);
    check({tag, "_req"}, {31'd0, reg_request}, 32'd1);
    check({tag, "_write"}, {31'd0, reg_write}, 32'd0);
    check({tag, "_addr"}, {16'd0, reg_addr}, {16'd0, addr});
    check({tag, "_in_ready"}, {31'd0, debug_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reg_ack   = 1'b1;
    reg_rdata = data;
    @(posedge clk);
    #1;
    reg_ack   = 1'b0;
    reg_rdata = 16'h0000;
    check({tag, "_req_drop"}, {31'd0, reg_request}, 32'd0);
  endtask

  task automatic collect(input int cycles, input bit bp);
    logic [15:0] prev;
    logic        pending;
    prev         = '0;
    pending      = 1'b0;
    rx_count     = 0;
    rx_first     = -1;
    hold_err     = 0;
    in_ready_err = 0;
    req_seen     = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      debug_out_ready = bp ? ((i % 4) == 3) : 1'b1;
      if (reg_request) req_seen++;
      if (debug_out.valid) begin
        if (debug_in_ready) in_ready_err++;
        if (pending && debug_out.data !== prev) hold_err++;
        if (debug_out_ready) begin
          if (rx_count < 16) begin
            rx_data[rx_count] = debug_out.data;
            rx_last[rx_count] = debug_out.last;
          end
          if (rx_first < 0) rx_first = i;
          rx_count++;
          pending = 1'b0;
        end else begin
          prev    = debug_out.data;
          pending = 1'b1;
        end
      end
    end
    debug_out_ready = 1'b1;
  endtask

  task automatic check_resp(input string tag, input int n, input logic [15:0] e0,
                            input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp [4];
    exp = '{e0, e1, e2, e3};
    check({tag, "_count"}, rx_count, n);
    for (int k = 0; k < n && k < rx_count; k++) begin
      check($sformatf("%s_w%0d", tag, k), {16'd0, rx_data[k]}, {16'd0, exp[k]});
      check($sformatf("%s_last%0d", tag, k), {31'd0, rx_last[k]}, {31'd0, k == n - 1});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    rst             = 1'b1;
    id              = 16'h0005;
    debug_in        = '0;
    debug_out_ready = 1'b1;
    reg_ack         = 1'b0;
    reg_err         = 1'b0;
    reg_rdata       = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, debug_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, debug_out.valid}, 32'd0);
    check("rst_req", {31'd0, reg_request}, 32'd0);
    check("rst_write", {31'd0, reg_write}, 32'd0);
    check("rst_addr", {16'd0, reg_addr}, 32'd0);
    check("rst_wdata", {16'd0, reg_wdata}, 32'd0);
    rst = 1'b0;

    // Basic read, response word0 the cycle after ack
    read_with_ack("rd", 16'h0010, 16'hBEEF);
    collect(12, 1'b0);
    check("rd_latency", rx_first, 0);
    check_resp("rd", 4, 16'h0001, 16'h0005, 16'h2000, 16'hBEEF);

    // Write acknowledged in the first ACCESS cycle
    send_write(16'h0020, 16'h1234);
    check("wr_req", {31'd0, reg_request}, 32'd1);
    check("wr_write", {31'd0, reg_write}, 32'd1);
    check("wr_addr", {16'd0, reg_addr}, 32'h0020);
    check("wr_wdata", {16'd0, reg_wdata}, 32'h1234);
    reg_ack = 1'b1;
    @(posedge clk);
    #1;
    reg_ack = 1'b0;
    collect(10, 1'b0);
    check_resp("wr", 3, 16'h0001, 16'h0005, 16'h2800, 16'h0000);

    // Write with err and ack together: error wins
    send_write(16'h0040, 16'h5678);
    reg_ack = 1'b1;
    reg_err = 1'b1;
    @(posedge clk);
    #1;
    reg_ack = 1'b0;
    reg_err = 1'b0;
    collect(10, 1'b0);
    check_resp("wrerr", 3, 16'h0001, 16'h0005, 16'h2C00, 16'h0000);

    // Timeout with TIMEOUT=4, response held off until counting ends
    debug_out_ready = 1'b0;
    send_read(16'h0010);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (reg_request) req_cycles++;
      @(posedge clk);
      #1;
    end
    check("to_req_cycles", req_cycles, 4);
    check("to_held_valid", {31'd0, debug_out.valid}, 32'd1);
    check("to_held_word0", {16'd0, debug_out.data}, 32'h0001);
    collect(10, 1'b0);
    check_resp("to", 3, 16'h0001, 16'h0005, 16'h2400, 16'h0000);

    // Malformed: last on flags word, silently dropped
    send_word(16'h0005, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0000, 1'b1);
    collect(12, 1'b0);
    check("mal_req_seen", req_seen, 0);
    check("mal_resp_count", rx_count, 0);
    read_with_ack("mal_rd", 16'h0044, 16'h1357);
    collect(12, 1'b0);
    check_resp("mal_rd", 4, 16'h0001, 16'h0005, 16'h2000, 16'h1357);

    // Read whose addr word lacks last: drained, then error response
    send_word(16'h0005, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(16'h0010, 1'b0);
    send_word(16'hFFFF, 1'b1);
    collect(12, 1'b0);
    check("drn_req_seen", req_seen, 0);
    check_resp("drn", 3, 16'h0001, 16'h0005, 16'h2400, 16'h0000);

    // Backpressure: ready low 3 cycles per word
    read_with_ack("bp", 16'h0030, 16'hCAFE);
    collect(24, 1'b1);
    check_resp("bp", 4, 16'h0001, 16'h0005, 16'h2000, 16'hCAFE);
    check("bp_hold_err", hold_err, 0);
    check("bp_in_ready_err", in_ready_err, 0);

    // Reset during ACCESS
    send_read(16'h0010);
    check("rsta_req_before", {31'd0, reg_request}, 32'd1);
    rst = 1'b1;
    #1;
    check("rsta_req", {31'd0, reg_request}, 32'd0);
    check("rsta_out_valid", {31'd0, debug_out.valid}, 32'd0);
    check("rsta_in_ready", {31'd0, debug_in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    collect(12, 1'b0);
    check("rsta_req_seen", req_seen, 0);
    check("rsta_resp_count", rx_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
